cpu_sequencer: RTL and testbench

Parametrised multi-cycle instruction sequencer. Successor to the single-issue CPU control FSM.
Drives the IFU fetch handshake, hands the instruction to the IDU, and sequences register read, ALU execute, data-memory access and writeback per decoded instruction type.
Owns the program counter, including branch/jump redirection, and traps illegal instructions.

---
 rtl/cpu_sequencer.sv | 253 +++++++++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cpu_sequencer                                                |
// | Description : Multi-cycle instruction sequencer. Runs the IFU fetch        |
// |               handshake, hands the instruction to the IDU, and sequences   |
// |               register read, ALU execute, data-memory access, writeback    |
// |               and PC commit. Illegal instruction classes trap.             |
// |               Optional macro CTRL_TIMEOUT_EN adds a watchdog on the fetch  |
// |               and memory handshakes.                                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cpu_sequencer #(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter int                TIMEOUT_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   output logic              fetch_en,
   output logic [ADDR_W-1:0] fetch_address,
   input  logic              fetch_done,
   input  logic [31:0]       fetch_instr,
   output logic [31:0]       dec_instr,
   input  logic [2:0]        instr_type,
   input  logic [4:0]        rd,
   input  logic [4:0]        rs1,
   input  logic [4:0]        rs2,
   input  logic [31:0]       imm,
   output logic [4:0]        rf_rs1,
   output logic [4:0]        rf_rs2,
   output logic              rf_we,
   output logic [1:0]        rf_wd_sel,
   output logic [4:0]        rf_wd_addr,
   output logic              alu_start,
   input  logic              alu_done,
   input  logic              alu_taken,
   output logic              mem_req,
   output logic              mem_we,
   input  logic              mem_done,
   output logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic              trap,
   output logic [1:0]        trap_cause
);

   // Instruction classes reported by the IDU
   localparam logic [2:0] c_T_RALU   = 3'd0;
   localparam logic [2:0] c_T_IALU   = 3'd1;
   localparam logic [2:0] c_T_LOAD   = 3'd2;
   localparam logic [2:0] c_T_STORE  = 3'd3;
   localparam logic [2:0] c_T_BRANCH = 3'd4;
   localparam logic [2:0] c_T_JAL    = 3'd5;

   localparam logic [1:0] c_CAUSE_ILLEGAL = 2'd1;
   localparam logic [1:0] c_CAUSE_FETCH   = 2'd2;
   localparam logic [1:0] c_CAUSE_MEM     = 2'd3;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_FETCH     = 4'd1,
      ST_DECODE    = 4'd2,
      ST_REG_READ  = 4'd3,
      ST_EXECUTE   = 4'd4,
      ST_MEM       = 4'd5,
      ST_WRITEBACK = 4'd6,
      ST_COMMIT    = 4'd7,
      ST_TRAP      = 4'd8
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_pc;
   logic [31:0]       r_dec_instr;
   logic [4:0]        r_rs1;
   logic [4:0]        r_rs2;
   logic [4:0]        r_rd;
   logic [31:0]       r_imm;
   logic [2:0]        r_type;
   logic              r_taken;
   logic              r_alu_issued;
   logic              r_trap;
   logic [1:0]        r_cause;
   logic              w_set_trap;
   logic [1:0]        w_cause_nxt;
   logic [ADDR_W-1:0] w_imm_ext;
   logic              w_redirect;

`ifdef CTRL_TIMEOUT_EN
   // Trap when the next waiting cycle would bring the counter to all-ones,
   // i.e. after (2^TIMEOUT_W - 1) cycles spent waiting for done.
   localparam logic [TIMEOUT_W-1:0] c_WAIT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
   logic [TIMEOUT_W-1:0] r_wait_cnt;

   // Watchdog: counts consecutive waiting cycles in FETCH or MEM, clears otherwise
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wait_cnt <= '0;
      end else if ((r_state == ST_FETCH && !fetch_done) ||
                   (r_state == ST_MEM   && !mem_done)) begin
         r_wait_cnt <= r_wait_cnt + 1'b1;
      end else begin
         r_wait_cnt <= '0;
      end
   end
`else
   logic [TIMEOUT_W-1:0] w_unused_timeout;
   assign w_unused_timeout = '0;
`endif

   // Immediate resized to the PC width (sign-extended when the PC is wider)
   generate
      if (ADDR_W <= 32) begin : g_imm_narrow
         assign w_imm_ext = r_imm[ADDR_W-1:0];
      end else begin : g_imm_wide
         assign w_imm_ext = {{(ADDR_W-32){r_imm[31]}}, r_imm};
      end
   endgenerate

   assign w_redirect = (r_type == c_T_JAL) || (r_type == c_T_BRANCH && r_taken);

   // State register plus instruction/operand latches, PC and sticky trap
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_pc         <= RESET_PC;
         r_dec_instr  <= '0;
         r_rs1        <= '0;
         r_rs2        <= '0;
         r_rd         <= '0;
         r_imm        <= '0;
         r_type       <= '0;
         r_taken      <= 1'b0;
         r_alu_issued <= 1'b0;
         r_trap       <= 1'b0;
         r_cause      <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_alu_issued <= (r_state == ST_EXECUTE);
         if (r_state == ST_FETCH && fetch_done) begin
            r_dec_instr <= fetch_instr;
         end
         if (r_state == ST_DECODE) begin
            r_rs1  <= rs1;
            r_rs2  <= rs2;
            r_rd   <= rd;
            r_imm  <= imm;
            r_type <= instr_type;
         end
         if (r_state == ST_EXECUTE && alu_done) begin
            r_taken <= alu_taken;
         end
         if (r_state == ST_COMMIT) begin
            r_pc <= w_redirect ? (r_pc + w_imm_ext) : (r_pc + ADDR_W'(4));
         end
         if (w_set_trap) begin
            r_trap  <= 1'b1;
            r_cause <= w_cause_nxt;
         end
      end
   end

   // Next-state decode and per-state handshake/strobe outputs
   always_comb begin
      w_state_nxt = r_state;
      w_set_trap  = 1'b0;
      w_cause_nxt = '0;
      fetch_en    = 1'b0;
      alu_start   = 1'b0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      rf_we       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (run) w_state_nxt = ST_FETCH;
         end
         ST_FETCH: begin
            fetch_en = 1'b1;
            if (fetch_done) begin
               w_state_nxt = ST_DECODE;
`ifdef CTRL_TIMEOUT_EN
            end else if (r_wait_cnt == c_WAIT_LAST) begin
               w_state_nxt = ST_TRAP;
               w_set_trap  = 1'b1;
               w_cause_nxt = c_CAUSE_FETCH;
`endif
            end
         end
         ST_DECODE: begin
            if (instr_type[2] && instr_type[1]) begin
               w_state_nxt = ST_TRAP;
               w_set_trap  = 1'b1;
               w_cause_nxt = c_CAUSE_ILLEGAL;
            end else if (instr_type == c_T_JAL) begin
               w_state_nxt = ST_WRITEBACK;
            end else begin
               w_state_nxt = ST_REG_READ;
            end
         end
         ST_REG_READ: begin
            w_state_nxt = ST_EXECUTE;
         end
         ST_EXECUTE: begin
            alu_start = !r_alu_issued;
            if (alu_done) begin
               w_state_nxt = (r_type == c_T_LOAD || r_type == c_T_STORE) ? ST_MEM : ST_WRITEBACK;
            end
         end
         ST_MEM: begin
            mem_req = 1'b1;
            mem_we  = (r_type == c_T_STORE);
            if (mem_done) begin
               w_state_nxt = (r_type == c_T_STORE) ? ST_COMMIT : ST_WRITEBACK;
`ifdef CTRL_TIMEOUT_EN
            end else if (r_wait_cnt == c_WAIT_LAST) begin
               w_state_nxt = ST_TRAP;
               w_set_trap  = 1'b1;
               w_cause_nxt = c_CAUSE_MEM;
`endif
            end
         end
         ST_WRITEBACK: begin
            rf_we = (r_rd != 5'd0) &&
                    (r_type == c_T_RALU || r_type == c_T_IALU ||
                     r_type == c_T_LOAD || r_type == c_T_JAL);
            w_state_nxt = ST_COMMIT;
         end
         ST_COMMIT: begin
            w_state_nxt = run ? ST_FETCH : ST_IDLE;
         end
         ST_TRAP: begin
            w_state_nxt = ST_TRAP;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign fetch_address = r_pc;
   assign pc            = r_pc;
   assign dec_instr     = r_dec_instr;
   assign rf_rs1        = r_rs1;
   assign rf_rs2        = r_rs2;
   assign rf_wd_addr    = r_rd;
   assign rf_wd_sel     = (r_type == c_T_LOAD) ? 2'd1 :
                          (r_type == c_T_JAL)  ? 2'd2 : 2'd0;
   assign busy          = (r_state != ST_IDLE) && (r_state != ST_TRAP);
   assign trap          = r_trap;
   assign trap_cause    = r_cause;

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cpu_sequencer                                             |
// | Description : Scoreboard bench for cpu_sequencer. Directed program with    |
// |               hand-computed fetch/mem/writeback/trap event stream.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_cpu_sequencer;

   localparam logic [1:0] EV_FETCH = 2'd0;
   localparam logic [1:0] EV_WB    = 2'd1;
   localparam logic [1:0] EV_MEM   = 2'd2;
   localparam logic [1:0] EV_TRAP  = 2'd3;

   typedef struct packed {
      logic [1:0]  kind;
      logic [31:0] data;
   } ev_t;

   logic        clk = 1'b0;
   logic        reset, run;
   logic        fetch_en, fetch_done;
   logic [31:0] fetch_address, fetch_instr, dec_instr, imm;
   logic [2:0]  instr_type;
   logic [4:0]  rd, rs1, rs2, rf_rs1, rf_rs2, rf_wd_addr;
   logic        rf_we, alu_start, alu_done, alu_taken, mem_req, mem_we, mem_done;
   logic [1:0]  rf_wd_sel, trap_cause;
   logic [31:0] pc;
   logic        busy, trap;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   ev_t exp_q[$];
   int  fetch_cyc[$];
   int  mem_len[$];
   int  trap_cyc = 0;

   // Program: instruction word plus per-instruction handshake latencies
   logic [31:0] prog_w [16];
   int          prog_lf[16];
   int          prog_la[16];
   int          prog_lm[16];
   logic        prog_tk[16];
   int          n_prog = 0;

   cpu_sequencer #(.ADDR_W(32), .RESET_PC(32'h100), .TIMEOUT_W(4)) dut (
      .clk(clk), .reset(reset), .run(run),
      .fetch_en(fetch_en), .fetch_address(fetch_address), .fetch_done(fetch_done),
      .fetch_instr(fetch_instr), .dec_instr(dec_instr), .instr_type(instr_type),
      .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
      .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_we(rf_we), .rf_wd_sel(rf_wd_sel),
      .rf_wd_addr(rf_wd_addr), .alu_start(alu_start), .alu_done(alu_done),
      .alu_taken(alu_taken), .mem_req(mem_req), .mem_we(mem_we), .mem_done(mem_done),
      .pc(pc), .busy(busy), .trap(trap), .trap_cause(trap_cause)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // IDU model: bench-private encoding {imm[13:0], rs2, rs1, rd, type}
   assign instr_type = dec_instr[2:0];
   assign rd         = dec_instr[7:3];
   assign rs1        = dec_instr[12:8];
   assign rs2        = dec_instr[17:13];
   assign imm        = {{18{dec_instr[31]}}, dec_instr[31:18]};

   task automatic add(input logic [2:0] t, input logic [4:0] d, input logic [31:0] im,
                      input int lf, input int la, input logic tk, input int lm);
      logic [31:0] w;
      w = {im[13:0], 5'd2, 5'd1, d, t};
      prog_w[n_prog]  = w;
      prog_lf[n_prog] = lf;
      prog_la[n_prog] = la;
      prog_tk[n_prog] = tk;
      prog_lm[n_prog] = lm;
      n_prog++;
   endtask

   task automatic expect_ev(input logic [1:0] k, input logic [31:0] d);
      exp_q.push_back(ev_t'({k, d}));
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic drain(input int max_cyc);
      for (int i = 0; i < max_cyc && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d expected events never seen (next kind=%0d data=%h)",
                  exp_q.size(), exp_q[0].kind, exp_q[0].data);
         exp_q.delete();
      end
      #1;
   endtask

   // Responders for IFU, ALU and data memory, driven on the falling edge
   initial begin
      int fidx = 0, cur = 0, f_wait = 0, a_wait = 0, m_wait = 0;
      bit a_act = 0;
      fetch_done = 0; fetch_instr = '0; alu_done = 0; alu_taken = 0; mem_done = 0;
      forever begin
         @(negedge clk);
         fetch_done = 0; alu_done = 0; alu_taken = 0; mem_done = 0;
         if (reset) begin
            f_wait = 0; a_act = 0; m_wait = 0;
         end else begin
            if (fetch_en && fidx < n_prog) begin
               f_wait++;
               if (f_wait == prog_lf[fidx]) begin
                  fetch_done  = 1;
                  fetch_instr = prog_w[fidx];
                  cur         = fidx;
                  fidx++;
                  f_wait      = 0;
               end
            end else begin
               f_wait = 0;
            end
            if (alu_start) begin
               a_act = 1; a_wait = 0;
            end
            if (a_act) begin
               if (a_wait == prog_la[cur]) begin
                  alu_done = 1; alu_taken = prog_tk[cur]; a_act = 0;
               end else begin
                  a_wait++;
               end
            end
            if (mem_req) begin
               m_wait++;
               if (m_wait == prog_lm[cur]) mem_done = 1;
            end else begin
               m_wait = 0;
            end
         end
      end
   end

   // Monitor: turns DUT activity into events and checks them against the queue
   initial begin
      logic pf = 0, pm = 0, pt = 0;
      int   m_run = 0;
      ev_t  got, want;
      forever begin
         @(negedge clk);
         got.kind = 2'd0;
         got.data = '0;
         if (fetch_en && !pf) begin
            got = ev_t'({EV_FETCH, fetch_address});
            fetch_cyc.push_back(cyc);
         end else if (mem_req && !pm) begin
            got = ev_t'({EV_MEM, 31'd0, mem_we});
         end else if (rf_we) begin
            got = ev_t'({EV_WB, 25'd0, rf_wd_sel, rf_wd_addr});
         end else if (trap && !pt) begin
            got = ev_t'({EV_TRAP, 30'd0, trap_cause});
            trap_cyc = cyc;
         end
         if ((fetch_en && !pf) || (mem_req && !pm) || rf_we || (trap && !pt)) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL event: unexpected kind=%0d data=%h, queue empty", got.kind, got.data);
            end else begin
               want = exp_q.pop_front();
               if (got !== want) begin
                  n_bad++;
                  $display("FAIL event: got kind=%0d data=%h, expected kind=%0d data=%h",
                           got.kind, got.data, want.kind, want.data);
               end
            end
         end
         if (mem_req) m_run++;
         else if (pm) begin
            mem_len.push_back(m_run);
            m_run = 0;
         end
         pf = fetch_en; pm = mem_req; pt = trap;
      end
   end

   initial begin
      reset = 1; run = 1;
      //   type  rd     imm         lf  la tk lm
      add(3'd0, 5'd5, 32'd0,        1,  0, 0, 0);   // 0x100 R rd5
      add(3'd1, 5'd7, 32'd12,       3,  2, 0, 0);   // 0x104 I rd7
      add(3'd5, 5'd1, 32'h0F8,      1,  0, 0, 0);   // 0x108 JAL -> 0x200
      add(3'd4, 5'd0, -32'sd8,      1,  1, 1, 0);   // 0x200 BR taken -> 0x1F8
      add(3'd5, 5'd0, 32'd8,        2,  0, 0, 0);   // 0x1F8 JAL rd0 -> 0x200
      add(3'd4, 5'd0, -32'sd8,      1,  1, 0, 0);   // 0x200 BR not taken -> 0x204
      add(3'd2, 5'd0, 32'd0,        1,  0, 0, 5);   // 0x204 LOAD rd0, mem 5
      add(3'd3, 5'd4, 32'd0,        1,  0, 0, 1);   // 0x208 STORE
      add(3'd2, 5'd9, 32'd0,        1,  1, 0, 2);   // 0x20C LOAD rd9
      add(3'd0, 5'd3, 32'd0,        2,  3, 0, 0);   // 0x210 R rd3
      add(3'd7, 5'd2, 32'd0,        1,  0, 0, 0);   // 0x214 illegal
      add(3'd0, 5'd4, 32'd0,        1,  0, 0, 0);   // 0x100 R rd4, run dropped
      add(3'd0, 5'd6, 32'd0,       15,  0, 0, 0);   // 0x100 done on 15th wait cycle
      add(3'd0, 5'd6, 32'd0,     1000,  0, 0, 0);   // 0x104 fetch never completes

      repeat (3) @(posedge clk);
      #1;
      check("reset_fetch_en", fetch_en, 0);
      check("reset_pc", pc, 32'h100);
      check("reset_dec_instr", dec_instr, 0);
      check("reset_strobes", {rf_we, alu_start, mem_req, busy}, 0);
      check("reset_trap", {trap, trap_cause}, 0);

      expect_ev(EV_FETCH, 32'h100); expect_ev(EV_WB, {25'd0, 2'd0, 5'd5});
      expect_ev(EV_FETCH, 32'h104); expect_ev(EV_WB, {25'd0, 2'd0, 5'd7});
      expect_ev(EV_FETCH, 32'h108); expect_ev(EV_WB, {25'd0, 2'd2, 5'd1});
      expect_ev(EV_FETCH, 32'h200); expect_ev(EV_FETCH, 32'h1F8);
      expect_ev(EV_FETCH, 32'h200); expect_ev(EV_FETCH, 32'h204);
      expect_ev(EV_MEM, 32'd0);     expect_ev(EV_FETCH, 32'h208);
      expect_ev(EV_MEM, 32'd1);     expect_ev(EV_FETCH, 32'h20C);
      expect_ev(EV_MEM, 32'd0);     expect_ev(EV_WB, {25'd0, 2'd1, 5'd9});
      expect_ev(EV_FETCH, 32'h210); expect_ev(EV_WB, {25'd0, 2'd0, 5'd3});
      expect_ev(EV_FETCH, 32'h214); expect_ev(EV_TRAP, 32'd1);

      reset = 0;
      @(posedge clk);
      #1;
      check("first_fetch_en", fetch_en, 1);
      check("first_fetch_address", fetch_address, 32'h100);
      drain(400);

      check("rtype_fetch_spacing", fetch_cyc.size() >= 2 ? fetch_cyc[1] - fetch_cyc[0] : 0, 6);
      check("load_mem_req_len", mem_len.size() >= 1 ? mem_len[0] : 0, 5);
      check("store_mem_req_len", mem_len.size() >= 2 ? mem_len[1] : 0, 1);

      repeat (5) @(posedge clk);
      #1;
      check("trap_flag", trap, 1);
      check("trap_cause_illegal", trap_cause, 1);
      check("trap_busy", busy, 0);
      check("trap_pc_frozen", pc, 32'h214);
      check("trap_fetch_en", fetch_en, 0);

      reset = 1; run = 0;
      repeat (3) @(posedge clk);
      #1 reset = 0;
      @(posedge clk);
      #1;
      check("post_reset_trap", {trap, trap_cause}, 0);
      check("post_reset_pc", pc, 32'h100);
      check("post_reset_dec_instr", dec_instr, 0);
      repeat (3) @(posedge clk);
      #1;
      check("idle_hold", {busy, fetch_en}, 0);

      expect_ev(EV_FETCH, 32'h100); expect_ev(EV_WB, {25'd0, 2'd0, 5'd4});
      run = 1;
      repeat (3) @(posedge clk);
      #1 run = 0;
      drain(100);
      repeat (4) @(posedge clk);
      #1;
      check("run_drop_pc", pc, 32'h104);
      check("run_drop_idle", {busy, fetch_en}, 0);

`ifdef CTRL_TIMEOUT_EN
      reset = 1;
      repeat (2) @(posedge clk);
      #1;
      fetch_cyc.delete();
      expect_ev(EV_FETCH, 32'h100); expect_ev(EV_WB, {25'd0, 2'd0, 5'd6});
      expect_ev(EV_FETCH, 32'h104); expect_ev(EV_TRAP, 32'd2);
      reset = 0; run = 1;
      drain(200);
      check("timeout_wait_cycles",
            fetch_cyc.size() >= 2 ? trap_cyc - fetch_cyc[fetch_cyc.size()-1] : 0, 15);
      check("timeout_fetch_en", fetch_en, 0);
      check("timeout_cause", trap_cause, 2);
`endif

      check("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
